// File: rtl/ifetch_queue.sv
// Instruction fetch front end: issues sequential word fetches under a credit limit,
// buffers in-order responses with their PCs, and discards in-flight fetches on redirect.
module ifetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        code_valid,
  output logic [31:0] code,
  output logic [31:0] code_pc,
  input  logic        code_ready
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned UW = CW + 1;
  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  logic [31:0]   r_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_out;
  logic [CW-1:0] r_disc;
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic          r_run;
  logic [31:0]   r_data [DEPTH];
  logic [31:0]   r_tag  [DEPTH];

  logic          w_pop;
  logic          w_fire;
  logic          w_resp;
  logic          w_drop;
  logic          w_push;
  logic [UW-1:0] w_used;
  logic [31:0]   w_target;

  // A pop this cycle frees its slot for a new request, sustaining one fetch per cycle.
  always_comb begin
    w_target       = redirect_pc & ALIGN_MASK;
    w_pop          = (r_count != '0) && code_ready && !redirect_valid;
    w_used         = UW'(r_count) + UW'(r_out) - UW'(w_pop);
    imem_req_valid = r_run && !redirect_valid && (w_used < UW'(DEPTH));
    imem_req_addr  = r_pc & ALIGN_MASK;
    w_fire         = imem_req_valid && imem_req_ready;
    // A response with nothing in flight is stale and is ignored outright.
    w_resp         = imem_resp_valid && (r_out != '0);
    w_drop         = w_resp && (redirect_valid || (r_disc != '0));
    w_push         = w_resp && !w_drop;
    code_valid     = (r_count != '0);
    code           = r_data[r_rptr];
    code_pc        = r_tag[r_rptr];
  end

  // Fetch PC, response PC tracking and in-flight bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run     <= 1'b0;
      r_pc      <= RESET_PC;
      r_resp_pc <= RESET_PC & ALIGN_MASK;
      r_out     <= '0;
      r_disc    <= '0;
    end else begin
      r_run <= 1'b1;
      r_out <= r_out + CW'(w_fire) - CW'(w_resp);
      if (redirect_valid) begin
        r_pc      <= w_target;
        r_resp_pc <= w_target;
        r_disc    <= r_out - CW'(w_resp);
      end else begin
        if (w_fire) begin
          r_pc <= r_pc + 32'd4;
        end
        if (w_push) begin
          r_resp_pc <= r_resp_pc + 32'd4;
        end
        if (w_drop) begin
          r_disc <= r_disc - CW'(1);
        end
      end
    end
  end

  // FIFO pointers and occupancy; a redirect flushes everything buffered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else if (redirect_valid) begin
      r_count <= '0;
      r_wptr  <= '0;
      r_rptr  <= '0;
    end else begin
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data <= '{default: '0};
      r_tag  <= '{default: '0};
    end else if (w_push) begin
      r_data[r_wptr] <= imem_resp_data;
      r_tag[r_wptr]  <= r_resp_pc;
    end
  end

endmodule

// File: tb/tb_ifetch_queue.sv
// Bench for ifetch_queue: in-order memory model with configurable latency and a
// scoreboard of expected (pc, word) pairs checked on every decode pop.
module tb_ifetch_queue;

  localparam int unsigned DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] MASK     = 32'hFFFF_FFFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        code_valid;
  logic [31:0] code;
  logic [31:0] code_pc;
  logic        code_ready = 1'b1;

  ifetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data (imem_resp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .code_valid     (code_valid),
    .code           (code),
    .code_pc        (code_pc),
    .code_ready     (code_ready)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] pc; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  exp_t        sb[$];
  mreq_t       mq[$];
  exp_t        mon_e;
  int          cyc = 0;
  int          mem_lat = 1;
  logic [31:0] exp_fetch = RESET_PC & MASK;
  int          n_checks = 0;
  int          n_fail = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory side: accept requests and predict the PC each one should carry.
  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      exp_fetch = RESET_PC & MASK;
    end else if (redirect_valid) begin
      exp_fetch = redirect_pc & MASK;
    end else if (imem_req_valid && imem_req_ready) begin
      mq.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
      sb.push_back('{pc: exp_fetch, data: mem_word(imem_req_addr)});
      exp_fetch = exp_fetch + 32'd4;
    end
  end

  always begin
    @(posedge clk);
    cyc++;
    #1;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
  end

  // Decode side: every pop must match the oldest surviving fetch.
  always @(negedge clk) begin
    if (!rst_n || redirect_valid) begin
      sb.delete();
    end else if (code_valid && code_ready) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL sb_pop: code_pc=%h popped but no fetch expected", code_pc);
      end else begin
        mon_e = sb.pop_front();
        if (code_pc !== mon_e.pc) begin
          n_fail++;
          $display("FAIL sb_pc: code_pc=%h expected %h", code_pc, mon_e.pc);
        end
        n_checks++;
        if (code !== mon_e.data) begin
          n_fail++;
          $display("FAIL sb_code: code=%h expected %h", code, mon_e.data);
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; code_ready = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0; mem_lat = 1;
    repeat (3) @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    n_checks++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL rst_code_valid: got %b want 0", code_valid); end
    n_checks++; if (code !== 32'h0) begin n_fail++; $display("FAIL rst_code: got %h want 0", code); end
    n_checks++; if (code_pc !== 32'h0) begin n_fail++; $display("FAIL rst_code_pc: got %h want 0", code_pc); end
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL first_req_valid: got %b want 1", imem_req_valid); end
    n_checks++; if (imem_req_addr !== (RESET_PC & MASK)) begin n_fail++; $display("FAIL first_req_addr: got %h want %h", imem_req_addr, RESET_PC & MASK); end
  endtask

  task automatic test_stream();
    logic [31:0] want;
    for (int i = 0; i < 10 && !code_valid; i++) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      want = 32'(k * 4);
      n_checks++; if (code_valid !== 1'b1) begin n_fail++; $display("FAIL stream_valid[%0d]: got %b want 1", k, code_valid); end
      n_checks++; if (code_pc !== want) begin n_fail++; $display("FAIL stream_pc[%0d]: got %h want %h", k, code_pc, want); end
      @(negedge clk);
    end
  endtask

  task automatic test_backpressure();
    int fires;
    rst_n = 1'b0; code_ready = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    fires = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) fires++;
    end
    n_checks++; if (fires !== DEPTH) begin n_fail++; $display("FAIL bp_fires: got %0d want %0d", fires, DEPTH); end
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid: got %b want 0", imem_req_valid); end
    n_checks++; if (code_valid !== 1'b1) begin n_fail++; $display("FAIL bp_code_valid: got %b want 1", code_valid); end
    tick();
    code_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (code_pc !== 32'h0) begin n_fail++; $display("FAIL bp_head0: got %h want 0", code_pc); end
    @(negedge clk);
    n_checks++; if (code_pc !== 32'h4) begin n_fail++; $display("FAIL bp_head1: got %h want 4", code_pc); end
  endtask

  task automatic test_redirect_drop();
    int fires;
    rst_n = 1'b0; code_ready = 1'b1; mem_lat = 3;
    repeat (2) tick();
    rst_n = 1'b1;
    fires = 0;
    for (int i = 0; i < 10 && fires < 2; i++) begin
      @(negedge clk);
      if (imem_req_valid && imem_req_ready) fires++;
    end
    n_checks++; if (fires !== 2) begin n_fail++; $display("FAIL rd_outstanding: got %0d want 2", fires); end
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rd_req_blocked: got %b want 0", imem_req_valid); end
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 20 && !code_valid; i++) @(negedge clk);
    n_checks++; if (code_valid !== 1'b1) begin n_fail++; $display("FAIL rd_timeout: code_valid=%b want 1", code_valid); end
    n_checks++; if (code_pc !== 32'h100) begin n_fail++; $display("FAIL rd_pc: got %h want 100", code_pc); end
    n_checks++; if (code !== mem_word(32'h100)) begin n_fail++; $display("FAIL rd_code: got %h want %h", code, mem_word(32'h100)); end
    mem_lat = 1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_redirect_align();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL al_req_blocked: got %b want 0", imem_req_valid); end
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL al_req_valid: got %b want 1", imem_req_valid); end
    n_checks++; if (imem_req_addr !== 32'h200) begin n_fail++; $display("FAIL al_addr: got %h want 200", imem_req_addr); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_back_to_back();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h300;
    tick();
    redirect_pc = 32'h400;
    @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_req_blocked: got %b want 0", imem_req_valid); end
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (imem_req_addr !== 32'h400) begin n_fail++; $display("FAIL b2b_addr: got %h want 400", imem_req_addr); end
    for (int i = 0; i < 10 && !code_valid; i++) @(negedge clk);
    n_checks++; if (code_pc !== 32'h400 || code_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_first_code: pc=%h valid=%b want 400/1", code_pc, code_valid); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ready_stall();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h500;
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", k, imem_req_valid); end
      n_checks++; if (imem_req_addr !== 32'h500) begin n_fail++; $display("FAIL stall_addr[%0d]: got %h want 500", k, imem_req_addr); end
    end
    tick();
    imem_req_ready = 1'b1;
    @(negedge clk);
    n_checks++; if (imem_req_addr !== 32'h500) begin n_fail++; $display("FAIL stall_xfer_addr: got %h want 500", imem_req_addr); end
    @(negedge clk);
    n_checks++; if (imem_req_addr !== 32'h504) begin n_fail++; $display("FAIL stall_next_addr: got %h want 504", imem_req_addr); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_wrap();
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (imem_req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_addr0: got %h want fffffffc", imem_req_addr); end
    @(negedge clk);
    n_checks++; if (imem_req_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr1: got %h want 0", imem_req_addr); end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_drain();
    tick();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 20 && (sb.size() != 0 || code_valid); i++) @(negedge clk);
    n_checks++; if (sb.size() != 0) begin n_fail++; $display("FAIL drain_sb: %0d entries left want 0", sb.size()); end
    n_checks++; if (code_valid !== 1'b0) begin n_fail++; $display("FAIL drain_code_valid: got %b want 0", code_valid); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_drop();
    test_redirect_align();
    test_back_to_back();
    test_ready_stall();
    test_wrap();
    test_drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
